skid_rr_arbiter: RTL and testbench
==================================

// Module: skid_rr_arbiter
// PURPOSE
//  Round-robin, packet-locked arbiter sharing one AXI-Stream skid path among N_SRC sources.
//  Grants one source per packet (until tlast) and forwards beats through a 1-deep registered
//  output stage that feeds skid_crd's in_* port. Enforces a MAX_BEATS packet-length limit by
//  forced truncation. Keeps a completed-packet counter for status.
// PARAMETERS
//  N_SRC      4    number of requesting sources, >= 2
//  n          5    data width in bytes
//  nb         n*8  data width in bits
//  MAX_BEATS  64   max beats per packet before forced tlast, >= 1
// PORTS
//  aclk        in   1          clock
//  aresetn     in   1          asynchronous reset, active low
//  in_tdata    in   N_SRC*nb   source data; source i at [i*nb +: nb]
//  in_tvalid   in   N_SRC      per-source valid
//  in_tlast    in   N_SRC      per-source end of packet
//  in_tready   out  N_SRC      per-source ready
//  out_tdata   out  nb         registered data to skid buffer
//  out_tvalid  out  1          registered valid
//  out_tlast   out  1          registered last (source tlast OR forced)
//  out_tready  in   1          downstream ready (skid_crd in_tready)
//  grant_id    out  $clog2(N_SRC)  currently/last granted source
//  busy        out  1          1 while state == LOCK
//  err_trunc   out  1          1-cycle pulse when a packet is truncated at MAX_BEATS
//  pkt_cnt     out  16         packets completed on output (out_tvalid&out_tready&out_tlast), wraps
// BEHAVIOUR
//  Reset (async, aresetn=0): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, out_tvalid=0,
//   out_tlast=0, out_tdata=0, in_tready=0, busy=0, err_trunc=0, pkt_cnt=0. Mid-operation reset
//   drops the beat held in the output stage and any partial packet; no recovery.
//  States: IDLE, LOCK.
//  IDLE: all in_tready=0. If any in_tvalid: grant first i with in_tvalid[i]=1, searching
//   rr_ptr, rr_ptr+1, ... mod N_SRC; grant_id<=i, beat_cnt<=0, ->LOCK next cycle. No request:
//   stay IDLE. Arbitration costs one IDLE cycle per packet.
//  LOCK: in_tready[grant_id] = ~out_tvalid | out_tready (combinational); all other in_tready=0.
//   Accept = in_tvalid[g] & in_tready[g]: out_tdata<=in data of g, out_tvalid<=1,
//   out_tlast<=in_tlast[g] | (beat_cnt==MAX_BEATS-1), beat_cnt<=beat_cnt+1.
//   Accept with final beat (tlast or forced) -> IDLE, rr_ptr<=(grant_id+1) mod N_SRC.
//   Forced with in_tlast[g]=0: err_trunc=1 for one cycle; the rest of the source packet
//   is arbitrated later as a new packet.
//   Grant held across idle gaps (in_tvalid[g]=0) until tlast; other requests wait.
//  Output stage: out_tvalid & ~out_tready -> out_* held stable (AXI rule); out_tvalid & out_tready
//   without a new accept -> out_tvalid<=0. Accept and drain in the same cycle are allowed, so a
//   locked packet streams at 1 beat/cycle. Latency input->output 1 cycle.
//  out_tvalid never depends combinationally on out_tready. in_tready is never asserted in IDLE.
//  grant_id holds its value in IDLE (last grant).
//  pkt_cnt increments on each output handshake with out_tlast=1; wraps 16'hFFFF->0.
//  rr_ptr wraps N_SRC-1 -> 0. A single requester is re-granted on every packet.
// TESTING
//  1 Sources 0..3 each send a 2-beat packet at once, out_tready=1 -> order 0,1,2,3;
//    each packet is 2 beats back-to-back, 1 IDLE cycle between packets; pkt_cnt=4.
//  2 Src 1 sends 3 beats while src 2 is valid; out_tready=0 for 5 cycles mid-packet ->
//    out_tdata stable, no src-2 beat interleaved; src 2 is granted after src-1 tlast.
//  3 MAX_BEATS=4, src 0 sends 6 beats with tlast on beat 6 -> out_tlast on beat 4,
//    err_trunc pulses once; beats 5-6 form a second packet; pkt_cnt=2.
//  4 Only src 3 requests, 3 packets -> all granted to src 3, rr_ptr wraps 0, grant_id=3.
//  5 aresetn low during beat 2 of a 4-beat packet -> all outputs 0 immediately;
//    after release, src 0 is granted first (rr_ptr=0).
//  6 Random valid/ready on all sources, 10k cycles, scoreboard per source ->
//    no loss, no reorder, no interleave within a packet, no AXI stability violations.

Source files
------------

// File: rtl/skid_rr_arbiter.sv
// rtl/skid_rr_arbiter.sv - packet-locked round-robin arbiter feeding a registered AXI-Stream stage
module skid_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int n         = 5,
  parameter int nb        = n * 8,
  parameter int MAX_BEATS = 64
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_SRC*nb-1:0]        in_tdata,
  input  logic [N_SRC-1:0]           in_tvalid,
  input  logic [N_SRC-1:0]           in_tlast,
  output logic [N_SRC-1:0]           in_tready,
  output logic [nb-1:0]              out_tdata,
  output logic                       out_tvalid,
  output logic                       out_tlast,
  input  logic                       out_tready,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_trunc,
  output logic [15:0]                pkt_cnt
);

  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [nb-1:0]   out_tdata_q;
  logic            out_tvalid_q;
  logic            out_tlast_q;
  logic            err_trunc_q;
  logic [15:0]     pkt_cnt_q;

  logic            arb_found;
  logic [GW-1:0]   arb_idx;
  logic            stage_free;
  logic            accept;
  logic            forced;
  logic            fin;
  logic [nb-1:0]   g_data;

  // First requester at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int cand;
      cand = (int'(rr_ptr_q) + k) % N_SRC;
      if (!arb_found && in_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(cand);
      end
    end
  end

  assign stage_free = ~out_tvalid_q | out_tready;
  assign accept     = (state_q == LOCK) & in_tvalid[grant_q] & stage_free;
  assign forced     = (beat_cnt_q == CW'(MAX_BEATS - 1));
  assign fin        = in_tlast[grant_q] | forced;
  assign g_data     = in_tdata[int'(grant_q)*nb +: nb];

  always_comb begin
    in_tready = '0;
    if (state_q == LOCK) in_tready[grant_q] = stage_free;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      beat_cnt_q   <= '0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      err_trunc_q  <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      err_trunc_q <= 1'b0;
      if (out_tvalid_q && out_tready && out_tlast_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;

      // Load and drain may coincide, giving one beat per cycle inside a packet.
      if (accept) begin
        out_tdata_q  <= g_data;
        out_tvalid_q <= 1'b1;
        out_tlast_q  <= fin;
      end else if (out_tready) begin
        out_tvalid_q <= 1'b0;
        out_tlast_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q    <= arb_idx;
            beat_cnt_q <= '0;
            state_q    <= LOCK;
          end
        end
        LOCK: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (fin) begin
              state_q     <= IDLE;
              rr_ptr_q    <= (grant_q == GW'(N_SRC - 1)) ? '0 : grant_q + GW'(1);
              err_trunc_q <= forced & ~in_tlast[grant_q];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tlast  = out_tlast_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == LOCK);
  assign err_trunc  = err_trunc_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_skid_rr_arbiter.sv
// tb/tb_skid_rr_arbiter.sv - randomized and directed bench for skid_rr_arbiter
module tb_skid_rr_arbiter;

  localparam int N    = 4;
  localparam int NB   = 40;
  localparam int MAXB = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N*NB-1:0] in_tdata;
  logic [N-1:0]    in_tvalid, in_tlast, in_tready;
  logic [NB-1:0]   out_tdata;
  logic            out_tvalid, out_tlast, out_tready;
  logic [1:0]      grant_id;
  logic            busy, err_trunc;
  logic [15:0]     pkt_cnt;

  skid_rr_arbiter #(.N_SRC(N), .n(5), .MAX_BEATS(MAXB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .grant_id(grant_id), .busy(busy), .err_trunc(err_trunc), .pkt_cnt(pkt_cnt)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0, n_total = 0;

  // Per-source beat streams: {last, src[7:0], seq[31:0]}
  logic [NB:0]   gen [N][512];
  int            gen_n[N], gen_rd[N];
  bit            vld[N], hs_in[N];
  int            vprob, rprob, cyc;
  logic [NB-1:0] ob_data[2048];
  logic          ob_last[2048];
  int            ob_cyc[2048];
  int            ob_n, err_n, stab_viol, rdy_viol;
  bit            prev_hold;
  logic [NB+1:0] prev_out;

  task automatic clear_engine();
    for (int i = 0; i < N; i++) begin
      gen_n[i] = 0; gen_rd[i] = 0; vld[i] = 0; hs_in[i] = 0;
    end
    for (int k = 0; k < 2048; k++) begin
      ob_data[k] = 'x; ob_last[k] = 1'bx; ob_cyc[k] = 0;
    end
    ob_n = 0; err_n = 0; stab_viol = 0; rdy_viol = 0; prev_hold = 0; cyc = 0;
    vprob = 100; rprob = 100;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; in_tvalid = '0; in_tdata = '0; in_tlast = '0; out_tready = 1'b0;
    clear_engine();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int k = 0; k < len; k++) begin
      gen[s][gen_n[s]] = {1'(k == len - 1), 8'(s), 32'(gen_n[s])};
      gen_n[s]++;
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, handshakes land on the next rising edge.
  task automatic step();
    for (int i = 0; i < N; i++) begin
      if (hs_in[i]) begin gen_rd[i]++; vld[i] = 0; hs_in[i] = 0; end
      if (!vld[i] && gen_rd[i] < gen_n[i] && int'($urandom_range(0, 99)) < vprob) vld[i] = 1;
      in_tvalid[i] = vld[i];
      in_tlast[i]  = vld[i] ? gen[i][gen_rd[i]][NB] : 1'b0;
      in_tdata[i*NB +: NB] = vld[i] ? gen[i][gen_rd[i]][NB-1:0] : '0;
    end
    out_tready = int'($urandom_range(0, 99)) < rprob;
    #1;
    if (prev_hold && {out_tvalid, out_tlast, out_tdata} !== prev_out) stab_viol++;
    prev_hold = out_tvalid && !out_tready;
    prev_out  = {out_tvalid, out_tlast, out_tdata};
    if (out_tvalid && out_tready && ob_n < 2048) begin
      ob_data[ob_n] = out_tdata; ob_last[ob_n] = out_tlast; ob_cyc[ob_n] = cyc; ob_n++;
    end
    if (err_trunc) err_n++;
    if ($countones(in_tready) > 1 || (in_tready != '0 && !busy)) rdy_viol++;
    for (int i = 0; i < N; i++) hs_in[i] = in_tvalid[i] && in_tready[i];
    @(negedge aclk);
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget, output bit ok);
    int c = 0;
    while (ob_n < target && c < budget) begin step(); c++; end
    ok = (ob_n >= target);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (out_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", out_tvalid); else n_pass++;
    n_total++; if (out_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", out_tlast); else n_pass++;
    n_total++; if (out_tdata !== '0) $display("FAIL reset_tdata got %h want 0", out_tdata); else n_pass++;
    n_total++; if (in_tready !== '0) $display("FAIL reset_in_tready got %b want 0", in_tready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (err_trunc !== 1'b0) $display("FAIL reset_err got %b want 0", err_trunc); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd0) $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); else n_pass++;
    n_total++; if (grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_id); else n_pass++;
  endtask

  task automatic test_rr_order();
    bit ok;
    do_reset();
    for (int s = 0; s < N; s++) add_pkt(s, 2);
    run_until(8, 60, ok);
    n_total++; if (!ok) $display("FAIL rr_timeout got %0d beats want 8", ob_n); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      logic [NB-1:0] ed;
      ed = {8'(k / 2), 32'(k % 2)};
      n_total++;
      if (ob_data[k] !== ed || ob_last[k] !== 1'(k % 2))
        $display("FAIL rr_beat%0d got %h/%b want %h/%b", k, ob_data[k], ob_last[k], ed, 1'(k % 2));
      else n_pass++;
    end
    for (int k = 1; k < 8; k++) begin
      int gap;
      gap = (k % 2 == 1) ? 1 : 2;
      n_total++;
      if (ob_cyc[k] - ob_cyc[k-1] != gap)
        $display("FAIL rr_gap%0d got %0d want %0d", k, ob_cyc[k] - ob_cyc[k-1], gap);
      else n_pass++;
    end
    n_total++; if (pkt_cnt !== 16'd4) $display("FAIL rr_pkt_cnt got %0d want 4", pkt_cnt); else n_pass++;
    n_total++; if (grant_id !== 2'd3) $display("FAIL rr_grant got %0d want 3", grant_id); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rr_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [NB-1:0] ed [5];
    logic          el [5];
    ed = '{{8'd1, 32'd0}, {8'd1, 32'd1}, {8'd1, 32'd2}, {8'd2, 32'd0}, {8'd2, 32'd1}};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    add_pkt(1, 3); add_pkt(2, 2);
    run_until(1, 20, ok);
    rprob = 0;
    repeat (5) step();
    rprob = 100;
    run_until(5, 40, ok);
    n_total++; if (!ok) $display("FAIL bp_timeout got %0d beats want 5", ob_n); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (ob_data[k] !== ed[k] || ob_last[k] !== el[k])
        $display("FAIL bp_beat%0d got %h/%b want %h/%b", k, ob_data[k], ob_last[k], ed[k], el[k]);
      else n_pass++;
    end
    n_total++; if (ob_cyc[1] - ob_cyc[0] != 6) $display("FAIL bp_stall got %0d want 6", ob_cyc[1] - ob_cyc[0]); else n_pass++;
    n_total++; if (stab_viol != 0) $display("FAIL bp_stability got %0d want 0", stab_viol); else n_pass++;
    n_total++; if (rdy_viol != 0) $display("FAIL bp_ready got %0d want 0", rdy_viol); else n_pass++;
  endtask

  task automatic test_truncation();
    bit ok;
    logic el [6];
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    add_pkt(0, 6);
    run_until(6, 40, ok);
    n_total++; if (!ok) $display("FAIL trunc_timeout got %0d beats want 6", ob_n); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (ob_data[k] !== {8'd0, 32'(k)} || ob_last[k] !== el[k])
        $display("FAIL trunc_beat%0d got %h/%b want %h/%b", k, ob_data[k], ob_last[k], {8'd0, 32'(k)}, el[k]);
      else n_pass++;
    end
    n_total++; if (err_n != 1) $display("FAIL trunc_err got %0d want 1", err_n); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd2) $display("FAIL trunc_pkt_cnt got %0d want 2", pkt_cnt); else n_pass++;
  endtask

  task automatic test_single_requester();
    bit ok;
    do_reset();
    repeat (3) add_pkt(3, 2);
    run_until(6, 60, ok);
    n_total++; if (!ok) $display("FAIL single_timeout got %0d beats want 6", ob_n); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (ob_data[k][NB-1 -: 8] !== 8'd3) $display("FAIL single_src%0d got %0d want 3", k, ob_data[k][NB-1 -: 8]);
      else n_pass++;
    end
    n_total++; if (grant_id !== 2'd3) $display("FAIL single_grant got %0d want 3", grant_id); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd3) $display("FAIL single_pkt_cnt got %0d want 3", pkt_cnt); else n_pass++;
    add_pkt(3, 1); add_pkt(0, 1);
    run_until(8, 30, ok);
    n_total++;
    if (ob_data[6][NB-1 -: 8] !== 8'd0 || ob_data[7][NB-1 -: 8] !== 8'd3)
      $display("FAIL single_wrap got %0d,%0d want 0,3", ob_data[6][NB-1 -: 8], ob_data[7][NB-1 -: 8]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    add_pkt(0, 1); add_pkt(1, 4);
    run_until(2, 30, ok);
    n_total++; if (grant_id !== 2'd1 || !ok) $display("FAIL mreset_pre got grant %0d want 1", grant_id); else n_pass++;
    #1 aresetn = 1'b0;
    #1;
    n_total++; if (out_tvalid !== 1'b0 || out_tlast !== 1'b0) $display("FAIL mreset_out got %b%b want 00", out_tvalid, out_tlast); else n_pass++;
    n_total++; if (out_tdata !== '0) $display("FAIL mreset_tdata got %h want 0", out_tdata); else n_pass++;
    n_total++; if (in_tready !== '0 || busy !== 1'b0) $display("FAIL mreset_ready got %b/%b want 0/0", in_tready, busy); else n_pass++;
    n_total++; if (pkt_cnt !== 16'd0) $display("FAIL mreset_pkt_cnt got %0d want 0", pkt_cnt); else n_pass++;
    n_total++; if (grant_id !== 2'd0) $display("FAIL mreset_grant got %0d want 0", grant_id); else n_pass++;
    @(negedge aclk);
    in_tvalid = '0; in_tlast = '0; in_tdata = '0;
    clear_engine();
    aresetn = 1'b1;
    add_pkt(1, 1); add_pkt(0, 1);
    run_until(2, 30, ok);
    n_total++;
    if (ob_data[0][NB-1 -: 8] !== 8'd0 || ob_data[1][NB-1 -: 8] !== 8'd1)
      $display("FAIL mreset_order got %0d,%0d want 0,1", ob_data[0][NB-1 -: 8], ob_data[1][NB-1 -: 8]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NB-1:0] exp_d [N][512];
    logic          exp_l [N][512];
    int exp_ptr[N];
    int err_exp, pkts, tot, c, cur_src;
    bit done;
    do_reset();
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 60; p++) add_pkt(s, int'($urandom_range(1, 7)));
    // Reference: each source stream is cut at its own tlast or after MAXB beats.
    err_exp = 0; pkts = 0; tot = 0;
    for (int s = 0; s < N; s++) begin
      int cnt = 0;
      exp_ptr[s] = 0;
      for (int i = 0; i < gen_n[s]; i++) begin
        bit lst, frc;
        lst = gen[s][i][NB];
        frc = (cnt == MAXB - 1);
        exp_d[s][i] = gen[s][i][NB-1:0];
        exp_l[s][i] = lst | frc;
        if (frc && !lst) err_exp++;
        if (lst | frc) begin pkts++; cnt = 0; end else cnt++;
        tot++;
      end
    end
    vprob = 70; rprob = 60;
    c = 0; done = 0;
    while (!done && c < 10000) begin
      step(); c++;
      done = (ob_n == tot);
      for (int s = 0; s < N; s++) if (gen_rd[s] != gen_n[s] && !hs_in[s]) done = 0;
    end
    n_total++; if (!done) $display("FAIL rand_timeout got %0d beats want %0d", ob_n, tot); else n_pass++;
    cur_src = -1;
    for (int k = 0; k < ob_n; k++) begin
      int s;
      s = int'(ob_data[k][NB-1 -: 8]);
      n_total++;
      if (s >= N || exp_ptr[s] >= gen_n[s] || ob_data[k] !== exp_d[s][exp_ptr[s]] || ob_last[k] !== exp_l[s][exp_ptr[s]]) begin
        $display("FAIL rand_beat%0d got %h/%b", k, ob_data[k], ob_last[k]);
      end else n_pass++;
      n_total++;
      if (cur_src >= 0 && s != cur_src) $display("FAIL rand_interleave%0d got src %0d want %0d", k, s, cur_src);
      else n_pass++;
      cur_src = (ob_last[k] === 1'b1) ? -1 : s;
      if (s < N) exp_ptr[s]++;
    end
    n_total++; if (pkt_cnt !== 16'(pkts)) $display("FAIL rand_pkt_cnt got %0d want %0d", pkt_cnt, pkts); else n_pass++;
    n_total++; if (err_n != err_exp) $display("FAIL rand_err got %0d want %0d", err_n, err_exp); else n_pass++;
    n_total++; if (stab_viol != 0) $display("FAIL rand_stability got %0d want 0", stab_viol); else n_pass++;
    n_total++; if (rdy_viol != 0) $display("FAIL rand_ready got %0d want 0", rdy_viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_backpressure();
    test_truncation();
    test_single_requester();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
